// File: rtl/core_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_mem_pkg : response-owner encoding and arbitration defaults
// Rev 1.0
// ----------------------------------------------------------------------------
package core_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// unified_mem_arbiter_if : fetch, data and memory-command bundle of the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic                d_req_i;
  logic                d_we_i;
  logic [ADDR_W-1:0]   d_addr_i;
  logic [DATA_W-1:0]   d_wdata_i;
  logic [DATA_W/8-1:0] d_be_i;
  logic                d_gnt_o;
  logic                d_rvalid_o;
  logic [DATA_W-1:0]   d_rdata_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [DATA_W-1:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

endinterface
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb_starve_ctr : data-first priority with a fetch starvation limit
// Rev 1.0
// ----------------------------------------------------------------------------
module arb_starve_ctr
  import core_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  localparam logic [STARVE_CNT_W-1:0] c_starve_max = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;

  always_comb begin
    if_gnt_o     = 1'b0;
    d_gnt_o      = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (!rst_i) begin
      if (if_req_i && d_req_i) begin
        // Fetch wins only once it has watched STARVE_MAX data grants go by.
        if (starve_cnt_q == c_starve_max) begin
          if_gnt_o = 1'b1;
        end else begin
          d_gnt_o = 1'b1;
        end
      end else begin
        if_gnt_o = if_req_i;
        d_gnt_o  = d_req_i;
      end

      if (!if_req_i || if_gnt_o) begin
        starve_cnt_d = '0;
      end else if (d_gnt_o) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// unified_mem_arbiter : shares one single-port memory between fetch and data
// Rev 1.0
// ----------------------------------------------------------------------------
module unified_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  unified_mem_arbiter_if.slave bus
);

  logic if_gnt;
  logic d_gnt;

  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;

  owner_e owner_q;
  owner_e owner_d;

  logic if_rvalid;
  logic d_rvalid;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (bus.if_req_i),
    .d_req_i  (bus.d_req_i),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_addr  = bus.d_addr_i;
      mem_wdata = bus.d_wdata_i;
      mem_be    = bus.d_be_i;
    end else if (if_gnt) begin
      mem_addr = bus.if_addr_i;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.mem_req_o   = if_gnt | d_gnt;
  assign bus.mem_we_o    = d_gnt & bus.d_we_i;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.mem_be_o    = mem_be;

  // Stores complete at grant, so only reads claim next cycle's read data.
  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt && !bus.d_we_i) begin
      owner_d = OWN_D;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid       = !rst_i && (owner_q == OWN_IF);
  assign d_rvalid        = !rst_i && (owner_q == OWN_D);
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.d_rvalid_o  = d_rvalid;
  assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = d_rvalid  ? bus.mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter : directed and random checks against a request-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int BE_W       = DATA_W / 8;
  localparam int MEM_WORDS  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Memory device: read data appears one cycle after the read command.
  logic [DATA_W-1:0] dev_mem  [MEM_WORDS];
  logic [DATA_W-1:0] gold_mem [MEM_WORDS];
  logic [DATA_W-1:0] dev_rdata = 32'hBAD0_BAD0;
  assign bus.mem_rdata_i = dev_rdata;

  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.mem_be_o[b]) dev_mem[bus.mem_addr_o[7:2]][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
        end
      end else begin
        dev_rdata <= dev_mem[bus.mem_addr_o[7:2]];
      end
    end
  end

  // Requester state: a request stays pending until granted.
  bit                f_pend, d_pend, d_we, rst_nxt;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;

  // Model: consecutive data wins while fetch waits, and who owns next cycle's response.
  int                m_starve;
  int                m_own;      // 0 none, 1 fetch, 2 data
  logic [DATA_W-1:0] m_data;

  int                last_gnt;   // observed from DUT: 0 none, 1 fetch, 2 data
  logic              o_if_rv, o_d_rv, o_mem_we;
  logic [DATA_W-1:0] o_if_rd, o_d_rd;
  int                cnt_gnt, cnt_rv;
  int                n_tests, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int                eg, exp_own, nown;
    logic [DATA_W-1:0] nd;
    @(posedge clk);
    #1;
    rst           = rst_nxt;
    bus.if_req_i  = f_pend;
    bus.if_addr_i = f_addr;
    bus.d_req_i   = d_pend;
    bus.d_we_i    = d_we;
    bus.d_addr_i  = d_addr;
    bus.d_wdata_i = d_wdata;
    bus.d_be_i    = d_be;
    @(negedge clk);

    if (rst)                   eg = 0;
    else if (f_pend && d_pend) eg = (m_starve == STARVE_MAX) ? 1 : 2;
    else if (d_pend)           eg = 2;
    else if (f_pend)           eg = 1;
    else                       eg = 0;
    exp_own = rst ? 0 : m_own;

    chk("if_gnt",  bus.if_gnt_o,  eg == 1);
    chk("d_gnt",   bus.d_gnt_o,   eg == 2);
    chk("mem_req", bus.mem_req_o, eg != 0);
    chk("mem_we",  bus.mem_we_o,  (eg == 2) && d_we);
    if (eg == 1) begin
      chk("mem_addr_if", bus.mem_addr_o, f_addr);
      chk("mem_be_if",   bus.mem_be_o,   0);
    end
    if (eg == 2) begin
      chk("mem_addr_d", bus.mem_addr_o, d_addr);
      if (d_we) begin
        chk("mem_wdata", bus.mem_wdata_o, d_wdata);
        chk("mem_be",    bus.mem_be_o,    d_be);
      end
    end
    chk("if_rvalid", bus.if_rvalid_o, exp_own == 1);
    chk("d_rvalid",  bus.d_rvalid_o,  exp_own == 2);
    chk("if_rdata",  bus.if_rdata_o,  (exp_own == 1) ? m_data : '0);
    chk("d_rdata",   bus.d_rdata_o,   (exp_own == 2) ? m_data : '0);

    last_gnt = bus.if_gnt_o ? 1 : (bus.d_gnt_o ? 2 : 0);
    o_if_rv  = bus.if_rvalid_o;
    o_d_rv   = bus.d_rvalid_o;
    o_if_rd  = bus.if_rdata_o;
    o_d_rd   = bus.d_rdata_o;
    o_mem_we = bus.mem_we_o;
    cnt_gnt += int'(bus.if_gnt_o | bus.d_gnt_o);
    cnt_rv  += int'(bus.if_rvalid_o) + int'(bus.d_rvalid_o);

    nown = 0;
    nd   = '0;
    if (eg == 1) begin
      nown = 1;
      nd   = gold_mem[f_addr[7:2]];
    end else if (eg == 2 && !d_we) begin
      nown = 2;
      nd   = gold_mem[d_addr[7:2]];
    end else if (eg == 2) begin
      for (int b = 0; b < BE_W; b++) begin
        if (d_be[b]) gold_mem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
    if (rst || !f_pend || eg == 1) m_starve = 0;
    else if (eg == 2)              m_starve++;
    m_own  = nown;
    m_data = nd;
    if (eg == 1) f_pend = 0;
    if (eg == 2) d_pend = 0;
  endtask

  task automatic new_reqs(input int pf, input int pd);
    if (!f_pend && $urandom_range(0, 99) < pf) begin
      f_pend = 1;
      f_addr = ADDR_W'($urandom_range(0, MEM_WORDS - 1) << 2);
    end
    if (!d_pend && $urandom_range(0, 99) < pd) begin
      d_pend  = 1;
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = ADDR_W'($urandom_range(0, MEM_WORDS - 1) << 2);
      d_wdata = $urandom;
      d_be    = BE_W'($urandom_range(0, 15));
    end
  endtask

  task automatic d_load(input logic [ADDR_W-1:0] a);
    d_pend = 1; d_we = 0; d_addr = a; d_wdata = '0; d_be = '0;
  endtask

  initial begin
    int exp40 [6];
    exp40 = '{2, 2, 2, 2, 1, 2};
    n_tests = 0; n_fail = 0; cnt_gnt = 0; cnt_rv = 0;
    m_starve = 0; m_own = 0; m_data = '0; last_gnt = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      dev_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      gold_mem[i] = dev_mem[i];
    end
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.d_req_i = 0; bus.d_we_i = 0;
    bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_be_i = '0;

    // Reset with both requesters asserting: nothing may be granted.
    rst_nxt = 1;
    f_pend = 1; f_addr = 32'h8; d_load(32'hC);
    repeat (3) begin
      step();
      chk("rst_no_gnt", last_gnt, 0);
    end
    f_pend = 0; d_pend = 0; rst_nxt = 0;
    step();
    chk("rel_if_rv", o_if_rv, 0);
    chk("rel_d_rv",  o_d_rv,  0);
    chk("rel_rdata", o_if_rd | o_d_rd, 0);

    // Fetch-only read of 0x10.
    dev_mem[4] = 32'h0050_0093; gold_mem[4] = 32'h0050_0093;
    f_pend = 1; f_addr = 32'h10;
    step();
    chk("r038_gnt", last_gnt, 1);
    step();
    chk("r038_rv", o_if_rv, 1);
    chk("r038_rd", o_if_rd, 32'h0050_0093);

    // Both request: data first, fetch next cycle.
    f_pend = 1; f_addr = 32'h14; d_load(32'h40);
    step();
    chk("r039_gnt", last_gnt, 2);
    step();
    chk("r039_d_rv",  o_d_rv,  1);
    chk("r039_if_rv", o_if_rv, 0);
    chk("r039_gnt2",  last_gnt, 1);
    step();

    // Six cycles of contention: D,D,D,D,IF,D.
    for (int i = 0; i < 6; i++) begin
      if (!f_pend) begin f_pend = 1; f_addr = ADDR_W'(i * 4); end
      d_load(ADDR_W'(32'h80 + i * 4));
      step();
      chk($sformatf("r040_gnt%0d", i), last_gnt, exp40[i]);
    end
    repeat (2) step();

    // Store then load back.
    d_pend = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    step();
    chk("r041_we", o_mem_we, 1);
    d_load(32'h20);
    step();
    chk("r041_no_rv", o_d_rv, 0);
    step();
    chk("r041_rv", o_d_rv, 1);
    chk("r041_rd", o_d_rd, 32'hDEAD_BEEF);

    // Reset right after a fetch grant drops its response.
    f_pend = 1; f_addr = 32'h10;
    step();
    chk("r042_gnt", last_gnt, 1);
    rst_nxt = 1; f_pend = 1; f_addr = 32'h18; d_load(32'h1C);
    step();
    chk("r042_rv1",  o_if_rv, 0);
    chk("r042_gnt0", last_gnt, 0);
    rst_nxt = 0; f_pend = 0; d_pend = 0;
    step();
    chk("r042_rv2", o_if_rv, 0);

    // Alternating fetch/load for ten cycles.
    cnt_gnt = 0; cnt_rv = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin f_pend = 1; f_addr = ADDR_W'(i * 8); end
      else            d_load(ADDR_W'(i * 8));
      step();
    end
    step();
    chk("r043_gnts", cnt_gnt, 10);
    chk("r043_rvs",  cnt_rv,  10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_nxt = ($urandom_range(0, 99) == 0);
      new_reqs(int'($urandom_range(20, 90)), int'($urandom_range(20, 90)));
      step();
    end
    rst_nxt = 0;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits; legal range 1..15.
REQ-004 SHALL have port clk_i  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port if_req_i  input  1  instruction fetch request.
REQ-007 SHALL have port if_addr_i  input  ADDR_W  fetch byte address, word aligned.
REQ-008 SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid_o  output  1  fetch read data valid.
REQ-010 SHALL have port if_rdata_o  output  DATA_W  fetch read data.
REQ-011 SHALL have port d_req_i  input  1  data request.
REQ-012 SHALL have port d_we_i  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr_i  input  ADDR_W  data byte address.
REQ-014 SHALL have port d_wdata_i  input  DATA_W  store data.
REQ-015 SHALL have port d_be_i  input  DATA_W/8  store byte enables.
REQ-016 SHALL have port d_gnt_o  output  1  data request accepted this cycle.
REQ-017 SHALL have port d_rvalid_o  output  1  load data valid.
REQ-018 SHALL have port d_rdata_o  output  DATA_W  load data.
REQ-019 SHALL have port mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_be_o  outputs  1/1/ADDR_W/DATA_W/DATA_W/8  single-port memory command.
REQ-020 SHALL have port mem_rdata_i  input  DATA_W  memory read data, valid exactly 1 cycle after a read command.

Function
REQ-021 SHALL issue at most one memory command per cycle; grants combinational in request cycle (zero-cycle accept).
REQ-022 SHALL pass the granted requester's address/we/wdata/be to mem_* unchanged; mem_we_o=0 and mem_be_o=0 for fetch.
REQ-023 SHALL default priority to data over fetch when both request.
REQ-024 SHALL keep 4-bit starve_cnt: increment when d granted while if_req_i=1; clear when fetch granted or if_req_i=0.
REQ-025 SHALL grant fetch over data when starve_cnt==STARVE_MAX and both request.
REQ-026 SHALL register response owner (NONE/IF/D) each cycle; owner=D only for granted loads, stores set NONE.
REQ-027 SHALL assert if_rvalid_o/d_rvalid_o for exactly one cycle, one cycle after the read grant, per registered owner; rdata outputs carry mem_rdata_i that cycle, zero otherwise.
REQ-028 SHALL produce no rvalid for stores; store complete at grant.
REQ-029 SHALL sustain back-to-back grants every cycle (full throughput, responses in grant order).
REQ-030 Requesters SHALL hold req and command stable until gnt; arbiter need not handle withdrawal.
REQ-031 SHALL drive mem_req_o=0 and all gnt=0 when no request.

Reset
REQ-032 SHALL, while rst_i=1 at a clock edge, set owner=NONE, starve_cnt=0.
REQ-033 SHALL force all gnt, rvalid, mem_req_o, mem_we_o to 0 while rst_i=1, regardless of requests.
REQ-034 SHALL drop any response pending when reset asserts mid-operation; no rvalid in the cycle after reset release unless granted in release cycle.
REQ-035 SHALL hold rdata outputs at 0 during and after reset until first valid response.

Structure
REQ-036 SHALL place owner enum (OWN_NONE, OWN_IF, OWN_D) and STARVE_MAX default in shared package core_mem_pkg.
REQ-037 SHALL implement as one module; sub-module arb_starve_ctr (priority + starvation counter) is natural and permitted.

Verification
REQ-038 Fetch only, if_addr_i=0x10 cycle N, mem_rdata_i=0x00500093 -> if_gnt_o=1 cycle N, if_rvalid_o=1 with 0x00500093 cycle N+1.
REQ-039 Both request, starve_cnt=0, d load 0x40 -> d_gnt_o=1, if_gnt_o=0; d_rvalid_o next cycle; if_rvalid_o stays 0.
REQ-040 d_req_i and if_req_i held high 6 cycles, STARVE_MAX=4 -> grants D,D,D,D,IF,D; starve_cnt returns 0 after IF grant.
REQ-041 Store d_addr_i=0x20, d_wdata_i=0xDEADBEEF, d_be_i=0xF -> mem_we_o=1 same cycle, no d_rvalid_o next cycle; following load 0x20 returns 0xDEADBEEF.
REQ-042 Fetch granted cycle N, rst_i=1 cycle N+1 -> if_rvalid_o=0 at N+1 and N+2, all gnt 0 during reset.
REQ-043 Alternating fetch/load every cycle 10 cycles -> 10 grants, 10 rvalids in grant order, no lost or duplicated response.
